// File: rtl/probe_unit.sv
// -----------------------------------------------------------------------------
// probe_unit
//
// Handles one TileLink B-channel Probe at a time for the L1 data cache.
// Flow: accept the Probe, read the metadata array, and shrink the line's
// permissions. Dirty lines hand the writeback (ProbeAckData) to the
// writeback unit. Clean lines and misses get a ProbeAck on C issued here.
// Any permission change is written back to the metadata array, and that
// write always happens before the ProbeAck.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   b_*                 Probe request (valid/ready, cap param, address, source)
//   meta_rd_*           metadata lookup request (idx + tag)
//   meta_resp_*         lookup result (hit, way, coherence state)
//   mshr_block          an MSHR owns this set; the probe must wait
//   wb_req_*, wb_done   ProbeAckData handoff to the writeback unit
//   c_*                 ProbeAck on the C channel (clean lines / misses)
//   meta_wr_*           metadata state write (set, way, new state)
//   busy                high whenever a probe is in flight
// -----------------------------------------------------------------------------
module probe_unit #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6,
  parameter int OFF_W  = 6,
  parameter int WAY_W  = 2,
  parameter int SRC_W  = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  // B channel
  input  logic                            b_valid,
  output logic                            b_ready,
  input  logic [1:0]                      b_param,
  input  logic [ADDR_W-1:0]               b_address,
  input  logic [SRC_W-1:0]                b_source,
  // metadata read
  output logic                            meta_rd_valid,
  input  logic                            meta_rd_ready,
  output logic [IDX_W-1:0]                meta_rd_idx,
  output logic [ADDR_W-IDX_W-OFF_W-1:0]   meta_rd_tag,
  input  logic                            meta_resp_valid,
  input  logic                            meta_resp_hit,
  input  logic [WAY_W-1:0]                meta_resp_way,
  input  logic [1:0]                      meta_resp_state,
  // MSHR conflict
  input  logic                            mshr_block,
  // writeback unit
  output logic                            wb_req_valid,
  input  logic                            wb_req_ready,
  output logic [2:0]                      wb_req_param,
  input  logic                            wb_done,
  // C channel
  output logic                            c_valid,
  input  logic                            c_ready,
  output logic [2:0]                      c_opcode,
  output logic [2:0]                      c_param,
  output logic [SRC_W-1:0]                c_source,
  output logic [ADDR_W-1:0]               c_address,
  // metadata write
  output logic                            meta_wr_valid,
  input  logic                            meta_wr_ready,
  output logic [IDX_W-1:0]                meta_wr_idx,
  output logic [WAY_W-1:0]                meta_wr_way,
  output logic [1:0]                      meta_wr_state,
  // status
  output logic                            busy
);

  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  // Coherence states
  localparam logic [1:0] ST_NOTHING = 2'd0;
  localparam logic [1:0] ST_BRANCH  = 2'd1;
  localparam logic [1:0] ST_TRUNK   = 2'd2;
  localparam logic [1:0] ST_DIRTY   = 2'd3;

  // Probe caps
  localparam logic [1:0] CAP_TOT = 2'd0;
  localparam logic [1:0] CAP_TOB = 2'd1;

  // Shrink/report params
  localparam logic [2:0] P_TTOB = 3'd0;
  localparam logic [2:0] P_TTON = 3'd1;
  localparam logic [2:0] P_BTON = 3'd2;
  localparam logic [2:0] P_TTOT = 3'd3;
  localparam logic [2:0] P_BTOB = 3'd4;
  localparam logic [2:0] P_NTON = 3'd5;

  localparam logic [2:0] OPC_PROBE_ACK = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_META_REQ,
    S_META_RESP,
    S_MSHR_WAIT,
    S_WB_REQ,
    S_WB_WAIT,
    S_META_WRITE,
    S_ACK
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched probe and lookup results
  logic [1:0]        r_param;
  logic [ADDR_W-1:0] r_addr;
  logic [SRC_W-1:0]  r_source;
  logic [WAY_W-1:0]  r_way;
  logic              r_dirty;
  logic [2:0]        r_shrink;
  logic [1:0]        r_next;

  // Combinational onProb result for the current lookup response
  logic [1:0] w_eff_state;
  logic       w_dirty;
  logic [2:0] w_shrink;
  logic [1:0] w_next;
  logic       w_needs_write;

  // {dirty, report param, next state} for a probe cap applied to a state.
  // A probed Dirty line always returns its data and keeps at most Trunk.
  // The reserved cap value 3 is treated as toN, the most conservative choice.
  function automatic logic [5:0] on_probe(input logic [1:0] cap,
                                          input logic [1:0] st);
    logic [5:0] res;
    res = {1'b0, P_NTON, ST_NOTHING};
    case (cap)
      CAP_TOT: begin
        case (st)
          ST_DIRTY:  res = {1'b1, P_TTOT, ST_TRUNK};
          ST_TRUNK:  res = {1'b0, P_TTOT, ST_TRUNK};
          ST_BRANCH: res = {1'b0, P_BTOB, ST_BRANCH};
          default:   res = {1'b0, P_NTON, ST_NOTHING};
        endcase
      end
      CAP_TOB: begin
        case (st)
          ST_DIRTY:  res = {1'b1, P_TTOB, ST_BRANCH};
          ST_TRUNK:  res = {1'b0, P_TTOB, ST_BRANCH};
          ST_BRANCH: res = {1'b0, P_BTOB, ST_BRANCH};
          default:   res = {1'b0, P_NTON, ST_NOTHING};
        endcase
      end
      default: begin
        case (st)
          ST_DIRTY:  res = {1'b1, P_TTON, ST_NOTHING};
          ST_TRUNK:  res = {1'b0, P_TTON, ST_NOTHING};
          ST_BRANCH: res = {1'b0, P_BTON, ST_NOTHING};
          default:   res = {1'b0, P_NTON, ST_NOTHING};
        endcase
      end
    endcase
    return res;
  endfunction

  // A miss behaves exactly like a line held in Nothing
  assign w_eff_state = meta_resp_hit ? meta_resp_state : ST_NOTHING;
  assign {w_dirty, w_shrink, w_next} = on_probe(r_param, w_eff_state);
  assign w_needs_write = meta_resp_hit && (w_next != w_eff_state);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and valid decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    b_ready       = 1'b0;
    meta_rd_valid = 1'b0;
    wb_req_valid  = 1'b0;
    meta_wr_valid = 1'b0;
    c_valid       = 1'b0;
    busy          = 1'b1;

    case (r_state)
      S_IDLE: begin
        b_ready = 1'b1;
        busy    = 1'b0;
        if (b_valid) begin
          w_state_next = S_META_REQ;
        end
      end

      S_META_REQ: begin
        meta_rd_valid = 1'b1;
        if (meta_rd_ready) begin
          w_state_next = S_META_RESP;
        end
      end

      S_META_RESP: begin
        if (meta_resp_valid) begin
          if (mshr_block) begin
            w_state_next = S_MSHR_WAIT;
          end else if (w_dirty) begin
            w_state_next = S_WB_REQ;
          end else if (w_needs_write) begin
            w_state_next = S_META_WRITE;
          end else begin
            w_state_next = S_ACK;
          end
        end
      end

      // The MSHR may change the line while we wait, so the lookup is redone
      S_MSHR_WAIT: begin
        if (!mshr_block) begin
          w_state_next = S_META_REQ;
        end
      end

      S_WB_REQ: begin
        wb_req_valid = 1'b1;
        if (wb_req_ready) begin
          w_state_next = S_WB_WAIT;
        end
      end

      S_WB_WAIT: begin
        if (wb_done) begin
          w_state_next = S_META_WRITE;
        end
      end

      // Dirty lines already answered with ProbeAckData, so they finish here
      S_META_WRITE: begin
        meta_wr_valid = 1'b1;
        if (meta_wr_ready) begin
          w_state_next = r_dirty ? S_IDLE : S_ACK;
        end
      end

      S_ACK: begin
        c_valid = 1'b1;
        if (c_ready) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Probe / lookup latches
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_param  <= '0;
      r_addr   <= '0;
      r_source <= '0;
      r_way    <= '0;
      r_dirty  <= 1'b0;
      r_shrink <= '0;
      r_next   <= '0;
    end else begin
      if (r_state == S_IDLE && b_valid) begin
        r_param  <= b_param;
        r_addr   <= b_address;
        r_source <= b_source;
      end
      // Re-lookups after an MSHR conflict overwrite the earlier result
      if (r_state == S_META_RESP && meta_resp_valid) begin
        r_way    <= meta_resp_way;
        r_dirty  <= w_dirty;
        r_shrink <= w_shrink;
        r_next   <= w_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Payloads come straight from the latches, so they hold steady under
  // backpressure
  // ---------------------------------------------------------------------------
  assign meta_rd_idx   = r_addr[IDX_W+OFF_W-1:OFF_W];
  assign meta_rd_tag   = r_addr[ADDR_W-1:IDX_W+OFF_W];
  assign meta_wr_idx   = r_addr[IDX_W+OFF_W-1:OFF_W];
  assign meta_wr_way   = r_way;
  assign meta_wr_state = r_next;
  assign wb_req_param  = r_shrink;
  assign c_opcode      = OPC_PROBE_ACK;
  assign c_param       = r_shrink;
  assign c_source      = r_source;
  assign c_address     = r_addr;

endmodule

// File: tb/tb_probe_unit.sv
// -----------------------------------------------------------------------------
// tb_probe_unit
//
// Testbench for probe_unit.
// - A table of probe scenarios is driven in a loop. Each row holds the cap,
//   the lookup result, and the expected param, write and next state.
// - Expected handshakes (wb request, metadata write, ProbeAck) are queued
//   in order when a probe is launched.
// - A monitor pops and compares them as the DUT completes each one.
// -----------------------------------------------------------------------------
module tb_probe_unit;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 6;
  localparam int OFF_W  = 6;
  localparam int WAY_W  = 2;
  localparam int SRC_W  = 4;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  localparam int K_WB = 0;
  localparam int K_MW = 1;
  localparam int K_ACK = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset;
  logic              b_valid, b_ready;
  logic [1:0]        b_param;
  logic [ADDR_W-1:0] b_address;
  logic [SRC_W-1:0]  b_source;
  logic              meta_rd_valid, meta_rd_ready;
  logic [IDX_W-1:0]  meta_rd_idx;
  logic [TAG_W-1:0]  meta_rd_tag;
  logic              meta_resp_valid, meta_resp_hit;
  logic [WAY_W-1:0]  meta_resp_way;
  logic [1:0]        meta_resp_state;
  logic              mshr_block;
  logic              wb_req_valid, wb_req_ready;
  logic [2:0]        wb_req_param;
  logic              wb_done;
  logic              c_valid, c_ready;
  logic [2:0]        c_opcode, c_param;
  logic [SRC_W-1:0]  c_source;
  logic [ADDR_W-1:0] c_address;
  logic              meta_wr_valid, meta_wr_ready;
  logic [IDX_W-1:0]  meta_wr_idx;
  logic [WAY_W-1:0]  meta_wr_way;
  logic [1:0]        meta_wr_state;
  logic              busy;

  probe_unit #(
    .ADDR_W(ADDR_W), .IDX_W(IDX_W), .OFF_W(OFF_W), .WAY_W(WAY_W), .SRC_W(SRC_W)
  ) dut (
    .clock(clock), .reset(reset),
    .b_valid(b_valid), .b_ready(b_ready), .b_param(b_param),
    .b_address(b_address), .b_source(b_source),
    .meta_rd_valid(meta_rd_valid), .meta_rd_ready(meta_rd_ready),
    .meta_rd_idx(meta_rd_idx), .meta_rd_tag(meta_rd_tag),
    .meta_resp_valid(meta_resp_valid), .meta_resp_hit(meta_resp_hit),
    .meta_resp_way(meta_resp_way), .meta_resp_state(meta_resp_state),
    .mshr_block(mshr_block),
    .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
    .wb_req_param(wb_req_param), .wb_done(wb_done),
    .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode),
    .c_param(c_param), .c_source(c_source), .c_address(c_address),
    .meta_wr_valid(meta_wr_valid), .meta_wr_ready(meta_wr_ready),
    .meta_wr_idx(meta_wr_idx), .meta_wr_way(meta_wr_way),
    .meta_wr_state(meta_wr_state),
    .busy(busy)
  );

  typedef struct {
    logic [1:0] cap;
    logic       hit;
    logic [1:0] st;
    logic [1:0] way;
    logic [2:0] exp_param;
    logic       exp_wr;
    logic [1:0] exp_next;
    logic       exp_dirty;
  } vec_t;

  typedef struct {
    int          kind;
    logic [2:0]  param;
    logic [1:0]  way;
    logic [1:0]  st;
    logic [3:0]  src;
    logic [31:0] addr;
  } ev_t;

  ev_t  sb[$];
  vec_t tbl[11];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare one completed handshake against the oldest expected event
  task automatic take(input int k);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_unexpected: got event kind %0d expected none", k);
    end else begin
      e = sb.pop_front();
      check("sb_kind", 64'(k), 64'(e.kind));
      if (k == K_WB) begin
        check("wb_param", wb_req_param, e.param);
      end else if (k == K_MW) begin
        check("mw_way", meta_wr_way, e.way);
        check("mw_state", meta_wr_state, e.st);
        check("mw_idx", meta_wr_idx, e.addr[11:6]);
      end else begin
        check("c_opcode", c_opcode, 3'd4);
        check("c_param", c_param, e.param);
        check("c_source", c_source, e.src);
        check("c_address", c_address, e.addr);
      end
    end
  endtask

  // Monitor: samples mid-low-phase, after the driver's negedge updates
  always @(negedge clock) begin
    #2;
    if (!reset) begin
      if (wb_req_valid && wb_req_ready)   take(K_WB);
      if (meta_wr_valid && meta_wr_ready) take(K_MW);
      if (c_valid && c_ready)             take(K_ACK);
    end
  end

  function automatic logic sig(input int k);
    case (k)
      0:       return b_ready;
      1:       return meta_rd_valid;
      2:       return wb_req_valid;
      3:       return c_valid;
      4:       return meta_wr_valid;
      default: return 1'b0;
    endcase
  endfunction

  // Returns on a negedge where the chosen output is high (bounded wait)
  task automatic wait_for(input int k, input string nm);
    int n;
    n = 0;
    @(negedge clock);
    while (!sig(k) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check({nm, "_seen"}, 64'(sig(k)), 64'd1);
  endtask

  task automatic do_probe(input vec_t v, input int blk, input logic [1:0] first_st,
                          input int c_stall, input int wb_hold,
                          input logic [3:0] src, input logic [31:0] addr);
    ev_t e;
    e.param = v.exp_param; e.way = v.way; e.st = v.exp_next; e.src = src; e.addr = addr;
    if (v.exp_dirty) begin e.kind = K_WB;  sb.push_back(e); end
    if (v.exp_wr)    begin e.kind = K_MW;  sb.push_back(e); end
    if (!v.exp_dirty) begin e.kind = K_ACK; sb.push_back(e); end

    @(negedge clock);
    check("idle_b_ready", b_ready, 1'b1);
    check("idle_busy", busy, 1'b0);
    b_valid = 1'b1; b_param = v.cap; b_address = addr; b_source = src;
    @(posedge clock); #1;
    b_valid = 1'b0; b_param = 2'($urandom); b_address = $urandom; b_source = 4'($urandom);

    for (int r = 0; r < ((blk > 0) ? 2 : 1); r++) begin
      wait_for(1, "meta_rd");
      check("rd_idx", meta_rd_idx, addr[11:6]);
      check("rd_tag", meta_rd_tag, addr[31:12]);
      meta_rd_ready = 1'b1;
      @(posedge clock); #1;
      meta_rd_ready   = 1'b0;
      meta_resp_valid = 1'b1;
      meta_resp_hit   = v.hit;
      meta_resp_way   = v.way;
      meta_resp_state = (r == 0 && blk > 0) ? first_st : v.st;
      mshr_block      = (r == 0 && blk > 0);
      @(posedge clock); #1;
      meta_resp_valid = 1'b0;
      meta_resp_state = 2'($urandom);
      if (r == 0 && blk > 0) begin
        for (int c = 0; c < blk; c++) begin
          @(negedge clock);
          check("blk_quiet", {meta_rd_valid, wb_req_valid, c_valid, meta_wr_valid}, 4'd0);
          check("blk_busy", busy, 1'b1);
        end
        @(posedge clock); #1;
        mshr_block = 1'b0;
      end
    end

    if (v.exp_dirty) begin
      wait_for(2, "wb_req");
      wb_req_ready = 1'b1;
      @(posedge clock); #1;
      wb_req_ready = 1'b0;
      for (int c = 0; c < wb_hold; c++) begin
        @(negedge clock);
        check("wb_wait_no_wr", {meta_wr_valid, c_valid}, 2'd0);
      end
      @(posedge clock); #1;
      wb_done = 1'b1;
      @(posedge clock); #1;
      wb_done = 1'b0;
    end

    if (v.exp_wr) begin
      wait_for(4, "meta_wr");
      meta_wr_ready = 1'b1;
      @(posedge clock); #1;
      meta_wr_ready = 1'b0;
    end

    if (!v.exp_dirty) begin
      wait_for(3, "c_ack");
      for (int c = 0; c < c_stall; c++) begin
        @(negedge clock);
        check("stall_c_valid", c_valid, 1'b1);
        check("stall_payload", {c_param, c_source, c_address}, {v.exp_param, src, addr});
        check("stall_b_ready", b_ready, 1'b0);
      end
      c_ready = 1'b1;
      @(posedge clock); #1;
      c_ready = 1'b0;
    end

    @(negedge clock);
    check("done_b_ready", b_ready, 1'b1);
    check("done_busy", busy, 1'b0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("probe cap=%0d hit=%0d st=%0d blk=%0d -> param %0d wr=%0d next=%0d dirty=%0d",
             v.cap, v.hit, v.st, blk, v.exp_param, v.exp_wr, v.exp_next, v.exp_dirty);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t mv;
    ev_t  e;
    //          cap   hit   st    way   param wr    next  dirty
    tbl[0]  = '{2'd2, 1'b1, 2'd1, 2'd2, 3'd2, 1'b1, 2'd0, 1'b0}; // toN Branch
    tbl[1]  = '{2'd1, 1'b1, 2'd3, 2'd1, 3'd0, 1'b1, 2'd1, 1'b1}; // toB Dirty
    tbl[2]  = '{2'd0, 1'b0, 2'd2, 2'd3, 3'd5, 1'b0, 2'd0, 1'b0}; // toT miss
    tbl[3]  = '{2'd0, 1'b1, 2'd2, 2'd0, 3'd3, 1'b0, 2'd2, 1'b0}; // toT Trunk
    tbl[4]  = '{2'd2, 1'b1, 2'd3, 2'd3, 3'd1, 1'b1, 2'd0, 1'b1}; // toN Dirty
    tbl[5]  = '{2'd1, 1'b1, 2'd2, 2'd1, 3'd0, 1'b1, 2'd1, 1'b0}; // toB Trunk
    tbl[6]  = '{2'd0, 1'b1, 2'd3, 2'd2, 3'd3, 1'b1, 2'd2, 1'b1}; // toT Dirty
    tbl[7]  = '{2'd1, 1'b1, 2'd1, 2'd0, 3'd4, 1'b0, 2'd1, 1'b0}; // toB Branch
    tbl[8]  = '{2'd2, 1'b1, 2'd0, 2'd1, 3'd5, 1'b0, 2'd0, 1'b0}; // toN Nothing
    tbl[9]  = '{2'd0, 1'b1, 2'd1, 2'd3, 3'd4, 1'b0, 2'd1, 1'b0}; // toT Branch
    tbl[10] = '{2'd2, 1'b1, 2'd2, 2'd2, 3'd1, 1'b1, 2'd0, 1'b0}; // toN Trunk

    reset = 1'b1;
    b_valid = 1'b0; b_param = '0; b_address = '0; b_source = '0;
    meta_rd_ready = 1'b0; meta_resp_valid = 1'b0; meta_resp_hit = 1'b0;
    meta_resp_way = '0; meta_resp_state = '0; mshr_block = 1'b0;
    wb_req_ready = 1'b0; wb_done = 1'b0; c_ready = 1'b0; meta_wr_ready = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_b_ready", b_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_valids", {meta_rd_valid, wb_req_valid, c_valid, meta_wr_valid}, 4'd0);
    check("rst_latches", {c_param, c_source, c_address}, '0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_probe(tbl[i], 0, 2'd0, 0, tbl[i].exp_dirty ? 5 : 0,
               4'(i + 3), 32'h8000_0000 | (i << 14) | ((i * 5) << 6) | 32'h15);
    end

    // MSHR conflict: first lookup says Dirty, the re-read says Trunk
    mv = '{2'd1, 1'b1, 2'd2, 2'd1, 3'd0, 1'b1, 2'd1, 1'b0};
    do_probe(mv, 4, 2'd3, 0, 0, 4'hA, 32'h1234_5678);

    // ProbeAck backpressure
    do_probe(tbl[3], 0, 2'd0, 10, 0, 4'h7, 32'hCAFE_0040);

    // Stray responses while idle are ignored
    @(posedge clock); #1;
    wb_done = 1'b1; meta_resp_valid = 1'b1; meta_resp_hit = 1'b1; meta_resp_state = 2'd3;
    @(posedge clock); #1;
    wb_done = 1'b0; meta_resp_valid = 1'b0;
    @(negedge clock);
    check("stray_b_ready", b_ready, 1'b1);
    check("stray_busy", busy, 1'b0);

    // Reset while waiting for the writeback to finish
    e.kind = K_WB; e.param = 3'd0; e.way = 2'd0; e.st = 2'd1; e.src = 4'h2; e.addr = 32'h0000_3000;
    sb.push_back(e);
    b_valid = 1'b1; b_param = 2'd1; b_address = 32'h0000_3000; b_source = 4'h2;
    @(posedge clock); #1;
    b_valid = 1'b0;
    wait_for(1, "rst_meta_rd");
    meta_rd_ready = 1'b1;
    @(posedge clock); #1;
    meta_rd_ready = 1'b0;
    meta_resp_valid = 1'b1; meta_resp_hit = 1'b1; meta_resp_way = 2'd0; meta_resp_state = 2'd3;
    @(posedge clock); #1;
    meta_resp_valid = 1'b0;
    wait_for(2, "rst_wb_req");
    wb_req_ready = 1'b1;
    @(posedge clock); #1;
    wb_req_ready = 1'b0;
    @(negedge clock);
    check("wbwait_busy", busy, 1'b1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("midrst_b_ready", b_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_valids", {meta_rd_valid, wb_req_valid, c_valid, meta_wr_valid}, 4'd0);
    check("midrst_sb", 64'(sb.size()), 64'd0);
    $display("probe reset during WB_WAIT -> idle");

    // A late wb_done for the discarded probe must not wake the unit
    @(posedge clock); #1;
    wb_done = 1'b1;
    @(posedge clock); #1;
    wb_done = 1'b0;
    repeat (2) @(negedge clock);
    check("late_done_idle", {b_ready, busy, meta_wr_valid}, 3'b100);

    // Normal operation resumes
    do_probe(tbl[0], 0, 2'd0, 0, 0, 4'h9, 32'h0BAD_F0C0);

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
